uart_rx_frame_ctrl: RTL



---
 rtl/uart_rx_frame_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame controller: oversampled 3-sample majority vote per bit,
// start/data/parity/stop FSM, LSB-first deserialiser, drives the downstream
// parity checker and merges its verdict with the stop check into data_valid.
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  serial_in,
  input  logic [5:0]            prescale,
  input  logic                  PAR_EN,
  input  logic                  parity_error,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  sampled_bit,
  output logic                  PAR_CHECK_EN,
  output logic                  RX_CHECK_EN,
  output logic                  data_valid,
  output logic                  stop_error,
  output logic                  strt_glitch,
  output logic                  busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q;
  logic [5:0]            edge_q;
  logic [BW-1:0]         bit_q;
  logic [5:0]            p_q;
  logic                  par_en_q;
  logic [2:0]            smp_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  sbit_q, par_chk_q, rx_chk_q, dv_q, serr_q, glitch_q, busy_q;

  logic [5:0] p_eff, h;
  logic       eob, maj;

  // Effective prescale: force even, clamp to a minimum of 8.
  always_comb begin
    p_eff = prescale & 6'b111110;
    if (p_eff < 6'd8) p_eff = 6'd8;
  end

  // Half-bit point, end-of-bit flag and majority of the three mid-bit samples.
  always_comb begin
    h   = {1'b0, p_q[5:1]};
    eob = (edge_q == p_q - 6'd1);
    maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
  end

  // Frame FSM with bit timing, sampling, deserialisation and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      edge_q    <= '0;
      bit_q     <= '0;
      p_q       <= 6'd8;
      par_en_q  <= 1'b0;
      smp_q     <= 3'b111;
      data_q    <= '0;
      sbit_q    <= 1'b1;
      par_chk_q <= 1'b0;
      rx_chk_q  <= 1'b0;
      dv_q      <= 1'b0;
      serr_q    <= 1'b0;
      glitch_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      par_chk_q <= 1'b0;
      rx_chk_q  <= 1'b0;
      dv_q      <= 1'b0;
      glitch_q  <= 1'b0;

      // Bit timing and mid-bit sampling run in every active state.
      if (state_q != IDLE) begin
        edge_q <= eob ? 6'd0 : edge_q + 6'd1;
        if (edge_q == h - 6'd1) smp_q[0] <= serial_in;
        if (edge_q == h)        smp_q[1] <= serial_in;
        if (edge_q == h + 6'd1) smp_q[2] <= serial_in;
        if (edge_q == h + 6'd2) sbit_q   <= maj;
      end

      case (state_q)
        IDLE: begin
          if (!serial_in) begin
            // Detection cycle is edge 0 of the start bit.
            state_q  <= START;
            edge_q   <= 6'd1;
            p_q      <= p_eff;
            par_en_q <= PAR_EN;
            rx_chk_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        START: begin
          if (eob) begin
            if (sbit_q) begin
              state_q  <= IDLE;
              glitch_q <= 1'b1;
              busy_q   <= 1'b0;
            end else begin
              state_q <= DATA;
              bit_q   <= '0;
            end
          end
        end
        DATA: begin
          if (eob) begin
            data_q[bit_q] <= sbit_q;
            if (bit_q == BW'(DATA_WIDTH - 1)) state_q <= par_en_q ? PARITY : STOP;
            else                               bit_q   <= bit_q + BW'(1);
          end
        end
        PARITY: begin
          if (eob) begin
            par_chk_q <= 1'b1;
            state_q   <= STOP;
          end
        end
        STOP: begin
          if (eob) begin
            serr_q  <= ~sbit_q;
            dv_q    <= sbit_q & (~par_en_q | ~parity_error);
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          edge_q  <= '0;
          bit_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign P_DATA       = data_q;
  assign sampled_bit  = sbit_q;
  assign PAR_CHECK_EN = par_chk_q;
  assign RX_CHECK_EN  = rx_chk_q;
  assign data_valid   = dv_q;
  assign stop_error   = serr_q;
  assign strt_glitch  = glitch_q;
  assign busy         = busy_q;

endmodule
